// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder and the timer control that consumes its events.
// State codes are fixed because STATEVAL exposes them on the debug port.
package button_event_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_PRESSED   = 2'b01,
    ST_LONG_HELD = 2'b10
  } state_e;

  // Default thresholds in 40 Hz ticks: 1 s to a long press, 200 ms between repeats.
  localparam int LONG_TICKS_1S      = 40;
  localparam int REPEAT_TICKS_200MS = 8;

  function automatic logic is_held(input state_e s);
    return (s == ST_PRESSED) || (s == ST_LONG_HELD);
  endfunction

endpackage

// File: rtl/button_event_decoder_edge_detector.sv
// Registers the debounced button level and flags its rising and falling edges.
// RISE/FALL are combinational and valid in the cycle the new level is presented.
module edge_detector (
  input  logic CLK,
  input  logic RESET,
  input  logic IN,
  output logic RISE,
  output logic FALL
);

  logic btn_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= IN;
    end
  end

  assign RISE = IN & ~btn_q;
  assign FALL = ~IN & btn_q;

endmodule

// File: rtl/button_event_decoder.sv
// Turns the debounced button level and the 40 Hz tick into single-cycle press/release/short/long/repeat
// pulses for the timer control FSM. All event outputs are registered.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int LONG_TICKS   = LONG_TICKS_1S,
  parameter int REPEAT_TICKS = REPEAT_TICKS_200MS,
  parameter int CNT_WIDTH    = 6
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 DIV_CLK,
  input  logic                 BTN_LEVEL,
  output logic                 PRESS_PULSE,
  output logic                 RELEASE_PULSE,
  output logic                 SHORT_PRESS,
  output logic                 LONG_PRESS,
  output logic                 REPEAT_PULSE,
  output logic                 HELD,
  output logic [1:0]           STATEVAL,
  output logic [CNT_WIDTH-1:0] HOLDVAL
);

  // Thresholds must fit the hold counter so it is always cleared before it could wrap.
  generate
    if (LONG_TICKS < 2 || LONG_TICKS > (2 ** CNT_WIDTH) - 1) begin : g_bad_long
      $error("LONG_TICKS out of range for CNT_WIDTH");
    end
    if (REPEAT_TICKS < 2 || REPEAT_TICKS > (2 ** CNT_WIDTH) - 1) begin : g_bad_repeat
      $error("REPEAT_TICKS out of range for CNT_WIDTH");
    end
  endgenerate

  localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  logic rise;
  logic fall;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 press_q;
  logic                 release_q;
  logic                 short_q;
  logic                 long_q;
  logic                 repeat_q;

  edge_detector u_edge (
    .CLK   (CLK),
    .RESET (RESET),
    .IN    (BTN_LEVEL),
    .RISE  (rise),
    .FALL  (fall)
  );

  // A release always beats a threshold tick arriving in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (rise) begin
            press_q <= 1'b1;
            state_q <= ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          if (fall) begin
            release_q <= 1'b1;
            short_q   <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
          end else if (DIV_CLK) begin
            if (cnt_q == LONG_LAST) begin
              long_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= ST_LONG_HELD;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        ST_LONG_HELD: begin
          if (fall) begin
            release_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
          end else if (DIV_CLK) begin
            if (cnt_q == REPEAT_LAST) begin
              repeat_q <= 1'b1;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          // Unused code 11: recover silently.
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign PRESS_PULSE   = press_q;
  assign RELEASE_PULSE = release_q;
  assign SHORT_PRESS   = short_q;
  assign LONG_PRESS    = long_q;
  assign REPEAT_PULSE  = repeat_q;
  assign HELD          = is_held(state_q);
  assign STATEVAL      = state_q;
  assign HOLDVAL       = cnt_q;

endmodule
